// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        WAIT_IDLE = 2'd1,
        RUN       = 2'd2,
        RECOVER   = 2'd3
    } rx_ctrl_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32'd8;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO only
// succeeds when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accept/reject decisions for this edge.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign count = count_r;
    assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Supervisor for uart_receiver: gates its reset on line idleness, recovers it
// after stop-bit errors and buffers completed frames for a valid/ready sink.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH_NUMBER = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH        = 8,
    parameter int IDLE_SAMPLES      = 20,
    parameter int RECOVER_CYCLES    = 4,
    parameter int ERR_CNT_WIDTH     = 8
) (
    input  logic                           sample_clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           line_in,
    input  logic [DATA_WIDTH_NUMBER-1:0]   rx_data,
    input  logic                           rx_done,
    input  logic                           rx_error,
    output logic                           rx_rst_n,
    output logic [DATA_WIDTH_NUMBER-1:0]   m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overrun,
    input  logic                           clr_status,
    output logic [ERR_CNT_WIDTH-1:0]       err_cnt,
    output logic                           busy
);

    localparam int IDLE_W = $clog2(IDLE_SAMPLES + 1);
    localparam int REC_W  = $clog2(RECOVER_CYCLES + 1);

    rx_ctrl_state_t           state_r;
    logic                     rx_rst_n_r;
    logic                     prev_rst_r;
    logic                     err_prev_r;
    logic [IDLE_W-1:0]        idle_cnt_r;
    logic [REC_W-1:0]         rec_cnt_r;
    logic                     overrun_r;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

    logic                     link_up_s;
    logic                     done_q_s;
    logic                     err_q_s;
    logic                     err_edge_s;
    logic                     pop_s;
    logic                     ovr_evt_s;
    logic                     full_s;
    logic                     empty_s;

    // Receiver outputs float while it is in reset, so only a solid 1 seen
    // after a full cycle out of reset counts.
    always_comb begin
        link_up_s  = (state_r == RUN) && prev_rst_r;
        done_q_s   = (rx_done === 1'b1) && link_up_s;
        err_q_s    = (rx_error === 1'b1) && link_up_s;
        err_edge_s = err_q_s && !err_prev_r;
        pop_s      = !empty_s && m_ready;
        ovr_evt_s  = done_q_s && full_s && !pop_s;
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH_NUMBER),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sample_clk),
        .rst_n (rst_n),
        .push  (done_q_s),
        .pop   (pop_s),
        .din   (rx_data),
        .dout  (m_data),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count)
    );

    // Control FSM; rx_rst_n is registered with the state so it rises on RUN entry.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= OFF;
            rx_rst_n_r <= 1'b0;
            idle_cnt_r <= IDLE_W'(0);
            rec_cnt_r  <= REC_W'(0);
        end else if (!enable) begin
            state_r    <= OFF;
            rx_rst_n_r <= 1'b0;
        end else begin
            case (state_r)
                OFF: begin
                    state_r    <= WAIT_IDLE;
                    idle_cnt_r <= IDLE_W'(0);
                    rx_rst_n_r <= 1'b0;
                end
                WAIT_IDLE: begin
                    if (line_in) begin
                        if (idle_cnt_r == IDLE_W'(IDLE_SAMPLES - 1)) begin
                            state_r    <= RUN;
                            rx_rst_n_r <= 1'b1;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt_r <= IDLE_W'(0);
                    end
                end
                RUN: begin
                    if (err_edge_s) begin
                        state_r    <= RECOVER;
                        rec_cnt_r  <= REC_W'(0);
                        rx_rst_n_r <= 1'b0;
                    end else begin
                        rx_rst_n_r <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (rec_cnt_r == REC_W'(RECOVER_CYCLES - 1)) begin
                        state_r    <= WAIT_IDLE;
                        idle_cnt_r <= IDLE_W'(0);
                    end else begin
                        rec_cnt_r <= rec_cnt_r + REC_W'(1);
                    end
                    rx_rst_n_r <= 1'b0;
                end
                default: begin
                    state_r    <= OFF;
                    rx_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

    // Error edge tracking plus sticky overrun and saturating error count;
    // a new event beats a coincident clear.
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rst_r <= 1'b0;
            err_prev_r <= 1'b0;
            overrun_r  <= 1'b0;
            err_cnt_r  <= ERR_CNT_WIDTH'(0);
        end else begin
            prev_rst_r <= rx_rst_n_r;
            err_prev_r <= rx_rst_n_r ? err_q_s : 1'b0;
            if (ovr_evt_s) begin
                overrun_r <= 1'b1;
            end else if (clr_status) begin
                overrun_r <= 1'b0;
            end
            if (err_edge_s) begin
                if (clr_status) begin
                    err_cnt_r <= ERR_CNT_WIDTH'(1);
                end else if (err_cnt_r != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
                end
            end else if (clr_status) begin
                err_cnt_r <= ERR_CNT_WIDTH'(0);
            end
        end
    end

    assign rx_rst_n = rx_rst_n_r;
    assign m_valid  = !empty_s;
    assign overrun  = overrun_r;
    assign err_cnt  = err_cnt_r;
    assign busy     = (state_r == RUN);

endmodule
